// File: rtl/uart_command_decoder.sv
// Byte-frame command decoder between the UART receiver and the ALU / register file.
// It parses write, read, burst-write and ALU commands, with an inter-frame timeout.
module uart_command_decoder #(
  parameter int unsigned DATA_WIDTH          = 8,
  parameter int unsigned REGISTER_FILE_DEPTH = 16,
  parameter int unsigned ALU_FUNCTION_WIDTH  = 4,
  parameter int unsigned TIMEOUT_CYCLES      = 1023,
  parameter logic [DATA_WIDTH-1:0] WRITE_CMD       = 'hAA,
  parameter logic [DATA_WIDTH-1:0] READ_CMD        = 'hBB,
  parameter logic [DATA_WIDTH-1:0] ALU_OPS_CMD     = 'hCC,
  parameter logic [DATA_WIDTH-1:0] ALU_NOOPS_CMD   = 'hDD,
  parameter logic [DATA_WIDTH-1:0] BURST_WRITE_CMD = 'hEE,
  parameter int unsigned OPERAND_A_ADDRESS = 0,
  parameter int unsigned OPERAND_B_ADDRESS = 1,
  localparam int unsigned AW = (REGISTER_FILE_DEPTH > 1) ? $clog2(REGISTER_FILE_DEPTH) : 1
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  input  logic                          i_enable,
  input  logic                          i_parallel_data_valid_synchronized,
  input  logic [DATA_WIDTH-1:0]         i_parallel_data_synchronized,
  output logic [ALU_FUNCTION_WIDTH-1:0] o_alu_function,
  output logic                          o_alu_enable,
  output logic                          o_alu_clk_enable,
  output logic [AW-1:0]                 o_address,
  output logic                          o_write_enable,
  output logic [DATA_WIDTH-1:0]         o_write_data,
  output logic                          o_read_enable,
  output logic                          o_busy,
  output logic                          o_command_error,
  output logic                          o_timeout_error
);

  // Timer only has to hold up to TIMEOUT_CYCLES-1.
  localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
  localparam logic [AW-1:0] ADDR_LAST  = AW'(REGISTER_FILE_DEPTH - 1);

  typedef enum logic [3:0] {
    StIdle, StWrAddr, StWrData, StRdAddr, StOpa, StOpb, StAluFunc,
    StAluWake, StAluEval, StAluDone, StBurstAddr, StBurstCount, StBurstData
  } state_e;

  state_e                        r_state;
  logic [AW-1:0]                 r_addr;
  logic [ALU_FUNCTION_WIDTH-1:0] r_func;
  logic [DATA_WIDTH-1:0]         r_count;
  logic [TW-1:0]                 r_timer;

  logic [ALU_FUNCTION_WIDTH-1:0] r_alu_function;
  logic                          r_alu_enable;
  logic                          r_alu_clk_enable;
  logic [AW-1:0]                 r_address;
  logic                          r_write_enable;
  logic [DATA_WIDTH-1:0]         r_write_data;
  logic                          r_read_enable;
  logic                          r_busy;
  logic                          r_command_error;
  logic                          r_timeout_error;

  logic                  w_strobe;
  logic [DATA_WIDTH-1:0] w_frame;
  logic [AW-1:0]         w_frame_addr;
  logic [AW-1:0]         w_addr_inc;
  logic                  w_window;
  logic                  w_counting;
  logic                  w_expire;

  assign w_strobe     = i_parallel_data_valid_synchronized;
  assign w_frame      = i_parallel_data_synchronized;
  assign w_frame_addr = w_frame[AW-1:0];
  assign w_addr_inc   = (r_addr == ADDR_LAST) ? '0 : r_addr + AW'(1);
  assign w_window     = (r_state == StAluWake) || (r_state == StAluEval) ||
                        (r_state == StAluDone);
  assign w_counting   = (r_state != StIdle) && !w_window;
  assign w_expire     = (TIMEOUT_CYCLES != 0) && (r_timer == TIMER_LAST);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state          <= StIdle;
      r_addr           <= '0;
      r_func           <= '0;
      r_count          <= '0;
      r_timer          <= '0;
      r_alu_function   <= '0;
      r_alu_enable     <= 1'b0;
      r_alu_clk_enable <= 1'b0;
      r_address        <= '0;
      r_write_enable   <= 1'b0;
      r_write_data     <= '0;
      r_read_enable    <= 1'b0;
      r_busy           <= 1'b0;
      r_command_error  <= 1'b0;
      r_timeout_error  <= 1'b0;
    end else begin
      r_alu_function   <= '0;
      r_alu_enable     <= 1'b0;
      r_alu_clk_enable <= 1'b0;
      r_address        <= '0;
      r_write_enable   <= 1'b0;
      r_write_data     <= '0;
      r_read_enable    <= 1'b0;
      r_command_error  <= 1'b0;
      r_timeout_error  <= 1'b0;
      if (w_strobe) begin
        r_timer <= '0;
      end

      unique case (r_state)
        StIdle: begin
          r_timer <= '0;
          if (w_strobe && i_enable) begin
            r_busy <= 1'b1;
            if (w_frame == WRITE_CMD) begin
              r_state <= StWrAddr;
            end else if (w_frame == READ_CMD) begin
              r_state <= StRdAddr;
            end else if (w_frame == ALU_OPS_CMD) begin
              r_state <= StOpa;
            end else if (w_frame == ALU_NOOPS_CMD) begin
              r_state <= StAluFunc;
            end else if (w_frame == BURST_WRITE_CMD) begin
              r_state <= StBurstAddr;
            end else begin
              r_busy          <= 1'b0;
              r_command_error <= 1'b1;
            end
          end
        end
        StWrAddr: begin
          if (w_strobe) begin
            r_addr  <= w_frame_addr;
            r_state <= StWrData;
          end
        end
        StWrData: begin
          if (w_strobe) begin
            r_write_enable <= 1'b1;
            r_address      <= r_addr;
            r_write_data   <= w_frame;
            r_state        <= StIdle;
            r_busy         <= 1'b0;
          end
        end
        StRdAddr: begin
          if (w_strobe) begin
            r_read_enable <= 1'b1;
            r_address     <= w_frame_addr;
            r_state       <= StIdle;
            r_busy        <= 1'b0;
          end
        end
        StOpa: begin
          if (w_strobe) begin
            r_write_enable <= 1'b1;
            r_address      <= AW'(OPERAND_A_ADDRESS);
            r_write_data   <= w_frame;
            r_state        <= StOpb;
          end
        end
        StOpb: begin
          if (w_strobe) begin
            r_write_enable <= 1'b1;
            r_address      <= AW'(OPERAND_B_ADDRESS);
            r_write_data   <= w_frame;
            r_state        <= StAluFunc;
          end
        end
        StAluFunc: begin
          if (w_strobe) begin
            r_func           <= w_frame[ALU_FUNCTION_WIDTH-1:0];
            r_alu_clk_enable <= 1'b1;
            r_state          <= StAluWake;
          end
        end
        // The ALU window runs on a fixed schedule; frames arriving inside it are dropped.
        StAluWake: begin
          r_command_error  <= w_strobe;
          r_alu_clk_enable <= 1'b1;
          r_alu_enable     <= 1'b1;
          r_alu_function   <= r_func;
          r_state          <= StAluEval;
        end
        StAluEval: begin
          r_command_error  <= w_strobe;
          r_alu_clk_enable <= 1'b1;
          r_state          <= StAluDone;
        end
        StAluDone: begin
          r_command_error <= w_strobe;
          r_state         <= StIdle;
          r_busy          <= 1'b0;
        end
        StBurstAddr: begin
          if (w_strobe) begin
            r_addr  <= w_frame_addr;
            r_state <= StBurstCount;
          end
        end
        StBurstCount: begin
          if (w_strobe) begin
            r_count <= w_frame;
            if (w_frame == '0) begin
              r_state <= StIdle;
              r_busy  <= 1'b0;
            end else begin
              r_state <= StBurstData;
            end
          end
        end
        StBurstData: begin
          if (w_strobe) begin
            r_write_enable <= 1'b1;
            r_address      <= r_addr;
            r_write_data   <= w_frame;
            r_addr         <= w_addr_inc;
            r_count        <= r_count - DATA_WIDTH'(1);
            if (r_count == DATA_WIDTH'(1)) begin
              r_state <= StIdle;
              r_busy  <= 1'b0;
            end
          end
        end
        default: begin
          r_state <= StIdle;
          r_busy  <= 1'b0;
        end
      endcase

      // A strobe in the expiry cycle takes priority over the timeout.
      if (w_counting && !w_strobe) begin
        if (w_expire) begin
          r_state         <= StIdle;
          r_busy          <= 1'b0;
          r_timeout_error <= 1'b1;
          r_timer         <= '0;
        end else begin
          r_timer <= r_timer + TW'(1);
        end
      end
    end
  end

  assign o_alu_function   = r_alu_function;
  assign o_alu_enable     = r_alu_enable;
  assign o_alu_clk_enable = r_alu_clk_enable;
  assign o_address        = r_address;
  assign o_write_enable   = r_write_enable;
  assign o_write_data     = r_write_data;
  assign o_read_enable    = r_read_enable;
  assign o_busy           = r_busy;
  assign o_command_error  = r_command_error;
  assign o_timeout_error  = r_timeout_error;

endmodule

// File: tb/tb_uart_command_decoder.sv
// Directed bench for uart_command_decoder with a short timeout (8 cycles).
module tb_uart_command_decoder;

  logic       clk;
  logic       rst_n;
  logic       enable;
  logic       valid;
  logic [7:0] data;
  logic [3:0] alu_function;
  logic       alu_enable;
  logic       alu_clk_enable;
  logic [3:0] address;
  logic       write_enable;
  logic [7:0] write_data;
  logic       read_enable;
  logic       busy;
  logic       command_error;
  logic       timeout_error;

  int n_cmp = 0;
  int n_err = 0;

  uart_command_decoder #(
    .TIMEOUT_CYCLES(8)
  ) dut (
    .i_clk                              (clk),
    .i_rst_n                            (rst_n),
    .i_enable                           (enable),
    .i_parallel_data_valid_synchronized (valid),
    .i_parallel_data_synchronized       (data),
    .o_alu_function                     (alu_function),
    .o_alu_enable                       (alu_enable),
    .o_alu_clk_enable                   (alu_clk_enable),
    .o_address                          (address),
    .o_write_enable                     (write_enable),
    .o_write_data                       (write_data),
    .o_read_enable                      (read_enable),
    .o_busy                             (busy),
    .o_command_error                    (command_error),
    .o_timeout_error                    (timeout_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Packed snapshot: we, re, busy, cerr, terr, clk_en, alu_en, func[4], addr[4], wdata[8].
  function automatic logic [22:0] ex(input logic we, input logic re, input logic bsy,
                                     input logic ce, input logic te, input logic cke,
                                     input logic ae, input logic [3:0] fn,
                                     input logic [3:0] ad, input logic [7:0] wd);
    return {we, re, bsy, ce, te, cke, ae, fn, ad, wd};
  endfunction

  task automatic check(input string tag, input logic [22:0] exp);
    logic [22:0] obs;
    obs = {write_enable, read_enable, busy, command_error, timeout_error, alu_clk_enable,
           alu_enable, alu_function, address, write_data};
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %06h expected %06h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; the strobe covers one cycle and returns mid-way through the next.
  task automatic strobe(input logic [7:0] d);
    valid = 1'b1;
    data  = d;
    @(negedge clk);
    valid = 1'b0;
    data  = 8'h00;
  endtask

  initial begin
    rst_n  = 1'b0;
    enable = 1'b1;
    valid  = 1'b0;
    data   = 8'h00;
    #12;
    check("reset_state", ex(0, 0, 0, 0, 0, 0, 0, 4'h0, 4'h0, 8'h00));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Single register write
    strobe(8'hAA); check("wr_cmd_busy", ex(0, 0, 1, 0, 0, 0, 0, 4'h0, 4'h0, 8'h00));
    strobe(8'h05); check("wr_addr_busy", ex(0, 0, 1, 0, 0, 0, 0, 4'h0, 4'h0, 8'h00));
    strobe(8'h3C); check("wr_data", ex(1, 0, 0, 0, 0, 0, 0, 4'h0, 4'h5, 8'h3C));
    @(negedge clk); check("wr_after", ex(0, 0, 0, 0, 0, 0, 0, 4'h0, 4'h0, 8'h00));

    // Operands then ALU function
    strobe(8'hCC); check("alu_cmd", ex(0, 0, 1, 0, 0, 0, 0, 4'h0, 4'h0, 8'h00));
    strobe(8'h12); check("opa_write", ex(1, 0, 1, 0, 0, 0, 0, 4'h0, 4'h0, 8'h12));
    strobe(8'h34); check("opb_write", ex(1, 0, 1, 0, 0, 0, 0, 4'h0, 4'h1, 8'h34));
    strobe(8'h01); check("alu_wake", ex(0, 0, 1, 0, 0, 1, 0, 4'h0, 4'h0, 8'h00));
    @(negedge clk); check("alu_eval", ex(0, 0, 1, 0, 0, 1, 1, 4'h1, 4'h0, 8'h00));
    @(negedge clk); check("alu_done", ex(0, 0, 1, 0, 0, 1, 0, 4'h0, 4'h0, 8'h00));
    @(negedge clk); check("alu_idle", ex(0, 0, 0, 0, 0, 0, 0, 4'h0, 4'h0, 8'h00));

    // No-operand ALU command with a frame dropped in the window
    strobe(8'hDD); check("noops_cmd", ex(0, 0, 1, 0, 0, 0, 0, 4'h0, 4'h0, 8'h00));
    strobe(8'h05); check("noops_wake", ex(0, 0, 1, 0, 0, 1, 0, 4'h0, 4'h0, 8'h00));
    strobe(8'h99); check("window_drop", ex(0, 0, 1, 1, 0, 1, 1, 4'h5, 4'h0, 8'h00));
    @(negedge clk); check("noops_done", ex(0, 0, 1, 0, 0, 1, 0, 4'h0, 4'h0, 8'h00));
    @(negedge clk); check("noops_idle", ex(0, 0, 0, 0, 0, 0, 0, 4'h0, 4'h0, 8'h00));

    // Burst with address wrap, then an empty burst
    strobe(8'hEE);
    strobe(8'h0E);
    strobe(8'h03); check("burst_count", ex(0, 0, 1, 0, 0, 0, 0, 4'h0, 4'h0, 8'h00));
    strobe(8'h11); check("burst_e", ex(1, 0, 1, 0, 0, 0, 0, 4'h0, 4'hE, 8'h11));
    strobe(8'h22); check("burst_f", ex(1, 0, 1, 0, 0, 0, 0, 4'h0, 4'hF, 8'h22));
    strobe(8'h33); check("burst_wrap", ex(1, 0, 0, 0, 0, 0, 0, 4'h0, 4'h0, 8'h33));
    strobe(8'hEE);
    strobe(8'h04);
    strobe(8'h00); check("burst_zero", ex(0, 0, 0, 0, 0, 0, 0, 4'h0, 4'h0, 8'h00));

    // Unknown command, disabled start, then a read
    strobe(8'h7F); check("unknown_cmd", ex(0, 0, 0, 1, 0, 0, 0, 4'h0, 4'h0, 8'h00));
    enable = 1'b0;
    strobe(8'hBB); check("disabled_cmd", ex(0, 0, 0, 0, 0, 0, 0, 4'h0, 4'h0, 8'h00));
    enable = 1'b1;
    strobe(8'h07); check("disabled_idle", ex(0, 0, 0, 1, 0, 0, 0, 4'h0, 4'h0, 8'h00));
    strobe(8'hBB);
    strobe(8'h07); check("read", ex(0, 1, 0, 0, 0, 0, 0, 4'h0, 4'h7, 8'h00));

    // Timeout after AA with silence: pulse in cycle N+9
    strobe(8'hAA);
    for (int i = 2; i <= 8; i++) begin
      @(negedge clk);
      check($sformatf("to_wait_%0d", i), ex(0, 0, 1, 0, 0, 0, 0, 4'h0, 4'h0, 8'h00));
    end
    @(negedge clk); check("timeout_pulse", ex(0, 0, 0, 0, 1, 0, 0, 4'h0, 4'h0, 8'h00));
    @(negedge clk); check("timeout_after", ex(0, 0, 0, 0, 0, 0, 0, 4'h0, 4'h0, 8'h00));

    // Strobe exactly at expiry is processed
    strobe(8'hAA);
    repeat (7) @(negedge clk);
    strobe(8'h05); check("expiry_strobe", ex(0, 0, 1, 0, 0, 0, 0, 4'h0, 4'h0, 8'h00));
    strobe(8'h3C); check("expiry_write", ex(1, 0, 0, 0, 0, 0, 0, 4'h0, 4'h5, 8'h3C));

    // Reset in the middle of a burst, then a normal write
    strobe(8'hEE);
    strobe(8'h00);
    strobe(8'h05);
    strobe(8'h11);
    strobe(8'h22);
    strobe(8'h33); check("burst_mid", ex(1, 0, 1, 0, 0, 0, 0, 4'h0, 4'h2, 8'h33));
    #2 rst_n = 1'b0;
    #1 check("mid_reset", ex(0, 0, 0, 0, 0, 0, 0, 4'h0, 4'h0, 8'h00));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk); check("post_reset_idle", ex(0, 0, 0, 0, 0, 0, 0, 4'h0, 4'h0, 8'h00));
    strobe(8'hAA);
    strobe(8'h02);
    strobe(8'h55); check("post_reset_write", ex(1, 0, 0, 0, 0, 0, 0, 4'h0, 4'h2, 8'h55));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/uart_command_decoder.md
# uart_command_decoder

Parametrised command decoder between the UART receiver (after the data synchroniser) and the ALU / register file of the system controller. It parses byte frames into register-file write, read, burst-write and ALU commands. All command codes and widths are parameters. It adds an auto-incrementing burst write, an inter-frame timeout with error reporting, unknown-command flagging, and a fixed three-cycle ALU clock-gate window. Every output is registered.

## Interface
- DATA_WIDTH, 8, frame width
- REGISTER_FILE_DEPTH, 16, register file entries; AW = $clog2(REGISTER_FILE_DEPTH)
- ALU_FUNCTION_WIDTH, 4, ALU function code width (≤ DATA_WIDTH)
- TIMEOUT_CYCLES, 1023, idle cycles allowed between frames of one command; 0 disables the timeout
- WRITE_CMD / READ_CMD / ALU_OPS_CMD / ALU_NOOPS_CMD / BURST_WRITE_CMD, 'hAA / 'hBB / 'hCC / 'hDD / 'hEE, command codes
- OPERAND_A_ADDRESS / OPERAND_B_ADDRESS, 0 / 1, operand register addresses
- clk  input  1  system clock
- reset  input  1  asynchronous, active-low reset
- enable  input  1  allows a new command to start (sampled only in IDLE)
- parallel_data_valid_synchronized  input  1  single-cycle strobe, one per frame
- parallel_data_synchronized  input  DATA_WIDTH  frame data, valid with the strobe
- ALU_function  output  ALU_FUNCTION_WIDTH  ALU operation code
- ALU_enable  output  1  ALU evaluate strobe
- ALU_clk_enable  output  1  ALU clock-gate enable
- address  output  AW  register file address
- write_enable  output  1  register file write strobe
- write_data  output  DATA_WIDTH  register file write data
- read_enable  output  1  register file read strobe
- busy  output  1  high whenever the state is not IDLE
- command_error  output  1  one-cycle pulse for an unknown command, or for a frame dropped during the ALU window
- timeout_error  output  1  one-cycle pulse when a command is aborted by timeout

## Operation
- States: IDLE, WR_ADDR, WR_DATA, RD_ADDR, OPA, OPB, ALU_FUNC, ALU_WAKE, ALU_EVAL, ALU_DONE, BURST_ADDR, BURST_COUNT, BURST_DATA.
- IDLE: a strobe with enable=1 decodes the command.
  - WRITE_CMD→WR_ADDR; READ_CMD→RD_ADDR; ALU_OPS_CMD→OPA; ALU_NOOPS_CMD→ALU_FUNC; BURST_WRITE_CMD→BURST_ADDR.
  - Any other code: stay in IDLE and pulse command_error.
  - A strobe with enable=0 is ignored silently.
- WR_ADDR: latch frame[AW-1:0] → WR_DATA. WR_DATA: write the frame to the latched address → IDLE.
- RD_ADDR: read_enable with address=frame[AW-1:0] → IDLE.
- OPA: write the frame to OPERAND_A_ADDRESS → OPB. OPB: write to OPERAND_B_ADDRESS → ALU_FUNC.
- ALU_FUNC: latch frame[ALU_FUNCTION_WIDTH-1:0] → ALU_WAKE → ALU_EVAL → ALU_DONE → IDLE, one cycle each.
- Strobes arriving in ALU_WAKE/EVAL/DONE are dropped with a command_error pulse.
- BURST_ADDR: latch the start address → BURST_COUNT. BURST_COUNT: latch N = frame.
  - N=0: go to IDLE with no writes.
  - N>0: go to BURST_DATA.
- BURST_DATA: each frame is written to the current address.
  - The address then increments modulo REGISTER_FILE_DEPTH (DEPTH-1 wraps to 0).
  - The remaining count decrements; at 0 → IDLE.
- Timeout: a counter clears on every strobe and on IDLE entry, and increments in every non-IDLE state except the ALU_WAKE/EVAL/DONE window.
  - When it reaches TIMEOUT_CYCLES: go to IDLE and pulse timeout_error.
  - Writes already performed are not undone.
  - A strobe arriving in the same cycle as expiry wins: the frame is processed and no timeout occurs.

## Timing
- Reset values: state IDLE; every output 0; latched address, function, count and timer 0. Reset mid-command aborts immediately without an error pulse.
- A strobe in cycle N produces its response in cycle N+1, and it lasts exactly one cycle:
  - write_enable / read_enable with address and write_data;
  - command_error;
  - the state change (busy follows).
- write_data, address and ALU_function are 0 whenever their strobes are low.
- ALU timing, for a function strobe in cycle N:
  - N+1 (ALU_WAKE): ALU_clk_enable=1.
  - N+2 (ALU_EVAL): ALU_clk_enable=1, ALU_enable=1, ALU_function=latched code.
  - N+3 (ALU_DONE): ALU_clk_enable=1.
  - N+4: IDLE, all ALU outputs 0.
- Back-to-back strobes (one cycle apart) are accepted in every state outside the ALU window.
- busy rises in N+1 after an accepted command strobe. It falls in the cycle the state returns to IDLE.
- Timeout, with the last strobe in cycle N: timeout_error pulses and busy falls in cycle N+TIMEOUT_CYCLES+1.

## Test plan
- AA, 05, 3C → write_enable one cycle with address=5, write_data=3C; busy falls in the same cycle; no error pulses.
- CC, 12, 34, 01 → writes 12@0 then 34@1; after the 01 strobe, ALU_clk_enable is high 3 cycles and ALU_enable pulses in the middle cycle with ALU_function=1; then IDLE.
- EE, 0E, 03, 11, 22, 33 (DEPTH=16) → writes 11@E, 22@F, 33@0 (wrap); EE, 04, 00 → no writes, IDLE.
- 7F in IDLE with enable=1 → command_error pulse, state stays IDLE. BB with enable=0 → ignored, no pulse.
- TIMEOUT_CYCLES=8: AA, then silence → timeout_error in cycle 9 after the AA strobe, IDLE, no write. A strobe exactly at expiry → processed, no timeout.
- Reset asserted while in BURST_DATA with 2 frames remaining → all outputs 0 immediately; after release, AA, 02, 55 → normal write 55@2.
